// File: rtl/slope_cycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// slope_cycle_ctrl_pkg
//   Shared encodings for the slope cycle controller and anything else that
//   consumes slope-detector direction flags.
//
//   Contents:
//     ST_*            FSM state encodings (IDLE, ARM, RUN, DONE)
//     DIR_*           direction encodings (NONE, POS, NEG)
//     dir_update()    next direction given current direction and posen/negen
// ---------------------------------------------------------------------------
package slope_cycle_ctrl_pkg;

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Direction of the sample stream as last reported by the slope detector
  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_POS  = 2'd1;
  localparam logic [1:0] DIR_NEG  = 2'd2;

  // A single asserted flag sets the direction. Both flags high is a detector
  // glitch and both low is a flat stretch; in either case the last known
  // direction is kept so a plateau does not look like a turning point.
  function automatic logic [1:0] dir_update(input logic [1:0] cur,
                                            input logic       posen,
                                            input logic       negen);
    logic [1:0] nxt;
    nxt = cur;
    case ({posen, negen})
      2'b10:   nxt = DIR_POS;
      2'b01:   nxt = DIR_NEG;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/slope_dir_track.sv
// ---------------------------------------------------------------------------
// slope_dir_track
//   Keeps the last known slope direction and flags turning points.
//
//   Ports:
//     clk        in   system clock
//     reset      in   asynchronous active-high reset (dir -> NONE)
//     clear      in   synchronous clear of dir to NONE (start of a new run)
//     posen      in   slope detector: sample rising
//     negen      in   slope detector: sample falling
//     trough_ev  out  falling -> rising turn seen this clock
//     peak_ev    out  rising -> falling turn seen this clock
//     dir_change out  direction register will change on this clock
// ---------------------------------------------------------------------------
module slope_dir_track
  import slope_cycle_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic posen,
  input  logic negen,
  output logic trough_ev,
  output logic peak_ev,
  output logic dir_change
);

  logic [1:0] dir_reg;
  logic [1:0] dir_next;

  always_comb begin
    dir_next = dir_update(dir_reg, posen, negen);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_reg <= DIR_NONE;
    end else if (clear) begin
      dir_reg <= DIR_NONE;
    end else begin
      dir_reg <= dir_next;
    end
  end

  // Events look at the registered direction and the live flags, so a turn is
  // reported in the same clock the detector first shows the new slope.
  // Requiring the opposite flag low keeps a both-high glitch from counting.
  assign trough_ev  = (dir_reg == DIR_NEG) && posen && !negen;
  assign peak_ev    = (dir_reg == DIR_POS) && negen && !posen;

  // NONE -> POS/NEG also counts as a change: the watchdog only needs to know
  // the stream is still moving.
  assign dir_change = (dir_next != dir_reg);

endmodule

// File: rtl/slope_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// slope_cycle_ctrl
//   Sequencer for a waveform generator + slope detector pair. Enables the
//   generator on start, waits for the first trough, then measures the
//   trough-to-trough period and the peak/trough sample values for a
//   programmed number of cycles before stopping the generator. A watchdog
//   aborts the run if the direction stops changing.
//
//   Ports:
//     clk           in   system clock, rising edge
//     reset         in   asynchronous active-high reset
//     start         in   begin a run (accepted only in IDLE or DONE)
//     ncycles       in   cycles to measure, sampled on accepted start (0 -> 1)
//     datain        in   current sample (same as slope detector input)
//     posen/negen   in   slope detector rising / falling flags
//     gen_en        out  waveform generator enable
//     busy          out  high in ARM or RUN
//     done          out  high in DONE
//     period        out  last trough-to-trough length in clocks
//     period_valid  out  one-clock pulse when period/peak/trough updated
//     peak          out  datain at the last rising->falling turn
//     trough        out  datain at the last falling->rising turn
//     cyc_done      out  cycles completed in this run
//     timeout_err   out  sticky watchdog flag, cleared by accepted start
// ---------------------------------------------------------------------------
module slope_cycle_ctrl
  import slope_cycle_ctrl_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int NCYC_WIDTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NCYC_WIDTH-1:0] ncycles,
  input  logic [WIDTH-1:0]      datain,
  input  logic                  posen,
  input  logic                  negen,
  output logic                  gen_en,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  period,
  output logic                  period_valid,
  output logic [WIDTH-1:0]      peak,
  output logic [WIDTH-1:0]      trough,
  output logic [NCYC_WIDTH-1:0] cyc_done,
  output logic                  timeout_err
);

  // Watchdog fires on the clock that would make TIMEOUT quiet clocks.
  localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT - 1);

  // Registered state
  logic [1:0]            state_reg,        state_next;
  logic [NCYC_WIDTH-1:0] ncyc_reg,         ncyc_next;
  logic [CNT_WIDTH-1:0]  cnt_reg,          cnt_next;
  logic [CNT_WIDTH-1:0]  wd_reg,           wd_next;
  logic [CNT_WIDTH-1:0]  period_reg,       period_next;
  logic [WIDTH-1:0]      peak_reg,         peak_next;
  logic [WIDTH-1:0]      trough_reg,       trough_next;
  logic [NCYC_WIDTH-1:0] cyc_done_reg,     cyc_done_next;
  logic                  period_valid_reg, period_valid_next;
  logic                  timeout_err_reg,  timeout_err_next;

  // Direction tracker interface
  logic dir_clear;
  logic trough_ev;
  logic peak_ev;
  logic dir_change;

  logic [NCYC_WIDTH-1:0] cyc_inc;

  slope_dir_track u_dir (
    .clk        (clk),
    .reset      (reset),
    .clear      (dir_clear),
    .posen      (posen),
    .negen      (negen),
    .trough_ev  (trough_ev),
    .peak_ev    (peak_ev),
    .dir_change (dir_change)
  );

  always_comb begin
    state_next        = state_reg;
    ncyc_next         = ncyc_reg;
    cnt_next          = cnt_reg;
    wd_next           = wd_reg;
    period_next       = period_reg;
    peak_next         = peak_reg;
    trough_next       = trough_reg;
    cyc_done_next     = cyc_done_reg;
    timeout_err_next  = timeout_err_reg;
    period_valid_next = 1'b0;
    dir_clear         = 1'b0;
    cyc_inc           = cyc_done_reg + NCYC_WIDTH'(1);

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        // Measured values are left alone so the last run stays readable
        // until a new run actually produces fresh ones.
        if (start) begin
          state_next       = ST_ARM;
          ncyc_next        = (ncycles == '0) ? NCYC_WIDTH'(1) : ncycles;
          cyc_done_next    = '0;
          timeout_err_next = 1'b0;
          cnt_next         = '0;
          wd_next          = '0;
          dir_clear        = 1'b1;
        end
      end

      ST_ARM, ST_RUN: begin
        // Watchdog: any direction change restarts it. A trough or peak is
        // itself a direction change, so an event on the expiry clock wins.
        if (dir_change) begin
          wd_next = '0;
        end else if (wd_reg == WD_LAST) begin
          wd_next          = '0;
          timeout_err_next = 1'b1;
          state_next       = ST_DONE;
        end else begin
          wd_next = wd_reg + CNT_WIDTH'(1);
        end

        if (state_reg == ST_ARM) begin
          // The first trough only opens the measurement window; the partial
          // cycle before it is not reported.
          if (trough_ev) begin
            state_next  = ST_RUN;
            cnt_next    = CNT_WIDTH'(1);
            trough_next = datain;
          end
        end else begin
          if (cnt_reg != '1) begin
            cnt_next = cnt_reg + CNT_WIDTH'(1);
          end

          if (peak_ev) begin
            peak_next = datain;
          end

          // The counter was set to 1 on the trough clock and counts every
          // clock after, so on the next trough it holds the full
          // trough-to-trough distance.
          if (trough_ev) begin
            period_next       = cnt_reg;
            trough_next       = datain;
            period_valid_next = 1'b1;
            cyc_done_next     = cyc_inc;
            cnt_next          = CNT_WIDTH'(1);
            if (cyc_inc == ncyc_reg) begin
              state_next = ST_DONE;
            end
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      ncyc_reg         <= '0;
      cnt_reg          <= '0;
      wd_reg           <= '0;
      period_reg       <= '0;
      peak_reg         <= '0;
      trough_reg       <= '0;
      cyc_done_reg     <= '0;
      period_valid_reg <= 1'b0;
      timeout_err_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      ncyc_reg         <= ncyc_next;
      cnt_reg          <= cnt_next;
      wd_reg           <= wd_next;
      period_reg       <= period_next;
      peak_reg         <= peak_next;
      trough_reg       <= trough_next;
      cyc_done_reg     <= cyc_done_next;
      period_valid_reg <= period_valid_next;
      timeout_err_reg  <= timeout_err_next;
    end
  end

  // Status is decoded straight from the state register: gen_en rises on the
  // clock start is accepted and drops on the clock DONE is entered.
  assign busy         = (state_reg == ST_ARM) || (state_reg == ST_RUN);
  assign gen_en       = busy;
  assign done         = (state_reg == ST_DONE);
  assign period       = period_reg;
  assign period_valid = period_valid_reg;
  assign peak         = peak_reg;
  assign trough       = trough_reg;
  assign cyc_done     = cyc_done_reg;
  assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_slope_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_slope_cycle_ctrl
//   Directed stimulus for slope_cycle_ctrl. Expected measurement results are
//   queued when a run is set up; a monitor pops and compares one entry on
//   every period_valid pulse. Status outputs are checked inline.
// ---------------------------------------------------------------------------
module tb_slope_cycle_ctrl;

  localparam int WIDTH      = 16;
  localparam int CNT_WIDTH  = 16;
  localparam int NCYC_WIDTH = 8;
  localparam int TIMEOUT    = 64;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [NCYC_WIDTH-1:0] ncycles = '0;
  logic [WIDTH-1:0]      datain = '0;
  logic                  posen = 1'b0;
  logic                  negen = 1'b0;
  logic                  gen_en;
  logic                  busy;
  logic                  done;
  logic [CNT_WIDTH-1:0]  period;
  logic                  period_valid;
  logic [WIDTH-1:0]      peak;
  logic [WIDTH-1:0]      trough;
  logic [NCYC_WIDTH-1:0] cyc_done;
  logic                  timeout_err;

  slope_cycle_ctrl #(
    .WIDTH      (WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .NCYC_WIDTH (NCYC_WIDTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ncycles      (ncycles),
    .datain       (datain),
    .posen        (posen),
    .negen        (negen),
    .gen_en       (gen_en),
    .busy         (busy),
    .done         (done),
    .period       (period),
    .period_valid (period_valid),
    .peak         (peak),
    .trough       (trough),
    .cyc_done     (cyc_done),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int peak;
    int trough;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   k     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic push(input int p, input int pk, input int tr, input int c);
    exp_t e;
    e.period = p;
    e.peak   = pk;
    e.trough = tr;
    e.cyc    = c;
    sb_q.push_back(e);
  endtask

  // Apply one clock worth of inputs, clock it, return 1 ns after the edge.
  task automatic drive(input logic p, input logic n, input logic [WIDTH-1:0] d, input logic s);
    posen  = p;
    negen  = n;
    datain = d;
    start  = s;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // dirv: 0 flat, 1 rising, 2 falling; datain is a running sample index.
  task automatic seg(input int dirv, input int len);
    for (int i = 0; i < len; i++) begin
      drive(dirv == 1, dirv == 2, WIDTH'(k), 1'b0);
      k++;
    end
  endtask

  // Triangle generator 0..15..1, period 30. The detector flags compare the
  // next sample with the presented one, so the turning sample itself is
  // presented on the clock the flag flips.
  function automatic int tri_wave(input int n);
    int m;
    m = n % 30;
    return (m < 16) ? m : 30 - m;
  endfunction

  task automatic tri_run(input int n_last);
    for (int n = 0; n <= n_last; n++) begin
      drive(tri_wave(n + 1) > tri_wave(n), tri_wave(n + 1) < tri_wave(n),
            WIDTH'(tri_wave(n)), 1'b0);
    end
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (period_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pv_unexpected: got period_valid=1 period=%0d expected no pulse", period);
        end else begin
          e = sb_q.pop_front();
          chk("pv_period", period, e.period);
          chk("pv_peak", peak, e.peak);
          chk("pv_trough", trough, e.trough);
          chk("pv_cyc_done", cyc_done, e.cyc);
        end
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_gen_en", gen_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pv", period_valid, 0);
    chk("rst_period", period, 0);
    chk("rst_cyc_done", cyc_done, 0);
    chk("rst_timeout", timeout_err, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Triangle source, 3 cycles: period 30, peak 15, trough 0
    ncycles = 8'd3;
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("tri_gen_en_start", gen_en, 1);
    chk("tri_busy_start", busy, 1);
    push(30, 15, 0, 1);
    push(30, 15, 0, 2);
    push(30, 15, 0, 3);
    tri_run(119);
    chk("tri_done_before_last", done, 0);
    tri_run(-1);
    drive(tri_wave(121) > tri_wave(120), tri_wave(121) < tri_wave(120),
          WIDTH'(tri_wave(120)), 1'b0);
    chk("tri_done", done, 1);
    chk("tri_gen_en_off", gen_en, 0);
    chk("tri_busy_off", busy, 0);
    chk("tri_cyc_done", cyc_done, 3);

    // Synthetic flags from DONE: NEG 10, POS 20, NEG 30, POS 5 -> period 50
    ncycles = 8'd1;
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("syn_restart_done", done, 0);
    chk("syn_restart_busy", busy, 1);
    k = 0;
    push(50, 30, 60, 1);
    seg(2, 10);
    seg(1, 20);
    seg(2, 30);
    seg(1, 5);
    chk("syn_done", done, 1);
    chk("syn_period", period, 50);

    // Watchdog: flat input after start
    ncycles = 8'd5;
    drive(1'b0, 1'b0, '0, 1'b1);
    for (int i = 1; i < TIMEOUT; i++) drive(1'b0, 1'b0, '0, 1'b0);
    chk("wd_not_yet", timeout_err, 0);
    chk("wd_busy_63", busy, 1);
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("wd_timeout_err", timeout_err, 1);
    chk("wd_done", done, 1);
    chk("wd_cyc_done", cyc_done, 0);
    chk("wd_gen_en", gen_en, 0);

    // start during RUN is ignored
    ncycles = 8'd2;
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("ign_timeout_clr", timeout_err, 0);
    k = 0;
    push(14, 10, 18, 1);
    push(16, 24, 34, 2);
    seg(2, 4);
    seg(1, 6);
    seg(2, 8);
    seg(1, 2);
    drive(1'b1, 1'b0, WIDTH'(k), 1'b1);
    k++;
    seg(1, 3);
    chk("ign_cyc_done", cyc_done, 1);
    chk("ign_busy", busy, 1);
    seg(2, 10);
    seg(1, 2);
    chk("ign_done", done, 1);
    chk("ign_cyc_done2", cyc_done, 2);

    // Restart from DONE with ncycles=0 -> one cycle
    ncycles = 8'd0;
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("n0_cyc_clr", cyc_done, 0);
    chk("n0_busy", busy, 1);
    k = 0;
    push(9, 7, 12, 1);
    seg(2, 3);
    seg(1, 4);
    seg(2, 5);
    seg(1, 1);
    chk("n0_done", done, 1);
    chk("n0_cyc_done", cyc_done, 1);

    // Asynchronous reset in the middle of RUN
    ncycles = 8'd3;
    drive(1'b0, 1'b0, '0, 1'b1);
    tri_run(44);
    chk("ar_busy_pre", busy, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_gen_en", gen_en, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_period", period, 0);
    chk("ar_peak", peak, 0);
    chk("ar_trough", trough, 0);
    chk("ar_cyc_done", cyc_done, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("ar_idle_busy", busy, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slope_cycle_ctrl.md
Name: slope_cycle_ctrl

Overview:
- Sequencer for the waveform-generator + slope-detector pair.
- Enables the generator on command and tracks direction changes from the slope detector's posen/negen.
- Measures period (samples trough-to-trough) plus peak/trough sample values for a programmed number of cycles, then stops the generator and reports done.
- Includes a stall watchdog.

Parameters:
- WIDTH, 16, width of sample data from generator/slope path.
- CNT_WIDTH, 16, width of period counter and watchdog counter.
- NCYC_WIDTH, 8, width of programmed cycle count.
- TIMEOUT, 1024, max clocks in RUN without a direction change before error.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-clock request to begin a measurement run; ignored unless IDLE or DONE.
- ncycles  in  NCYC_WIDTH  number of full cycles to measure; sampled on accepted start; 0 treated as 1.
- datain  in  WIDTH  current sample (same as slope detector input).
- posen  in  1  slope detector: sample rising.
- negen  in  1  slope detector: sample falling.
- gen_en  out  1  enable to waveform generator.
- busy  out  1  high in ARM or RUN.
- done  out  1  high in DONE until next start or reset.
- period  out  CNT_WIDTH  last measured trough-to-trough clocks.
- period_valid  out  1  one-clock pulse when period/peak/trough updated.
- peak  out  WIDTH  datain captured at last pos->neg change.
- trough  out  WIDTH  datain captured at last neg->pos change.
- cyc_done  out  NCYC_WIDTH  completed cycles this run.
- timeout_err  out  1  sticky until next accepted start or reset.

Behaviour:
- Reset (async, immediate): state=IDLE; gen_en, busy, done, period_valid, timeout_err = 0; period, peak, trough, cyc_done = 0; dir = NONE.
- Direction register dir ∈ {NONE, POS, NEG}:
  - posen=1 → POS; negen=1 → NEG.
  - Both high → treated as neither (glitch); dir holds.
  - Both low (flat) → dir holds.
- Events (combinational from registered dir and current inputs):
  - trough_ev = dir==NEG && posen && !negen.
  - peak_ev = dir==POS && negen && !posen.
- FSM:
  - IDLE: gen_en=0. On start → ARM, latch ncycles (0→1), clear cyc_done/timeout_err/dir, gen_en=1 next clock.
  - ARM: gen_en=1, busy=1. Wait for first trough_ev; on it → RUN, period counter=1, trough<=datain. No period_valid for the partial first cycle. Watchdog active.
  - RUN: gen_en=1, busy=1.
    - Period counter increments each clock, saturating at all-ones.
    - peak_ev: peak<=datain.
    - trough_ev: period<=counter; trough<=datain; period_valid=1 next clock; cyc_done++; counter=1.
    - If cyc_done reaches latched ncycles → DONE.
  - DONE: gen_en=0 the clock after entry, busy=0, done=1; outputs hold. start → ARM (same as from IDLE).
- Watchdog: counts clocks since last dir change in ARM/RUN; reaching TIMEOUT → timeout_err=1, gen_en=0, → DONE with cyc_done as-is.
- start while busy: ignored (no restart).
- trough_ev and watchdog expiry same clock: event wins, watchdog cleared.
- Latency: start→gen_en high = 1 clock; final trough_ev→done high = 1 clock.

Decomposition:
- Shared package/header: FSM state encodings (IDLE, ARM, RUN, DONE), dir encodings (NONE, POS, NEG).
- One natural sub-module: slope_dir_track (dir register + trough_ev/peak_ev generation), reusable by other slope consumers.
- Period/watchdog counters and FSM stay in the top.

Test Plan:
- Reset mid-RUN → all outputs zero immediately (async), gen_en=0, state IDLE.
- Drive real generator + slope detector; start with ncycles=3 → three period_valid pulses with equal period; peak = generator max, trough = generator min; done=1; gen_en=0 one clock after final trough.
- Synthetic posen/negen: NEG 10 clocks, POS 20, NEG 30, POS 5 → first period_valid with period=50.
- Hold posen=negen=0 after start, TIMEOUT=64 → timeout_err=1 at clock 64, done=1, cyc_done=0.
- Pulse start during RUN → no effect on counters; then start in DONE → cyc_done cleared, new run completes.
- ncycles=0 → behaves as 1: one period_valid, then done.
